// File: rtl/switch_button_io.sv
// Switch and push-button input port: synchronises, debounces and latches button presses,
// then serves a 4-register read window on the CPU IO bus.
module switch_button_io #(
    parameter int unsigned SW_WIDTH   = 24,
    parameter int unsigned BTN_WIDTH  = 5,
    parameter int unsigned DB_CYCLES  = 100000,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  SwitchCtrl,
    input  logic                  ioRead,
    input  logic [1:0]            addr,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic [BTN_WIDTH-1:0]  buttons,
    output logic [DATA_WIDTH-1:0] input_data,
    output logic                  btn_event
);

    localparam int unsigned IN_W  = SW_WIDTH + BTN_WIDTH;
    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [IN_W-1:0]       sync1, sync2;
    logic [IN_W-1:0]       hist0, hist1;
    logic [IN_W-1:0]       level, level_next, agree;
    logic [CNT_W-1:0]      count;
    logic                  tick;
    logic [BTN_WIDTH-1:0]  pending, pending_next, rise, clear_mask;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic                  rd_en;

    // Two-flop synchroniser for every raw pin; buttons sit above the switches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {buttons, switches};
            sync2 <= sync1;
        end
    end

    // Debounce sample prescaler.
    assign tick = (count == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // A bit qualifies when the current sample matches both stored samples.
    always_comb begin
        agree      = ~(sync2 ^ hist0) & ~(sync2 ^ hist1);
        level_next = level;
        if (tick) begin
            level_next = (agree & sync2) | (~agree & level);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist0 <= '0;
            hist1 <= '0;
            level <= '0;
        end else begin
            if (tick) begin
                hist0 <= sync2;
                hist1 <= hist0;
            end
            level <= level_next;
        end
    end

    // Sticky press flags; a fresh rise overrides a read-to-clear on the same edge.
    always_comb begin
        rd_en        = SwitchCtrl & ioRead;
        rise         = level_next[IN_W-1:SW_WIDTH] & ~level[IN_W-1:SW_WIDTH];
        clear_mask   = '0;
        if (rd_en && (addr == 2'd2)) begin
            clear_mask = pending;
        end
        pending_next = (pending & ~clear_mask) | rise;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign btn_event = |pending;

    // Register map read mux.
    always_comb begin
        rd_data_c = '0;
        case (addr)
            2'd0:    rd_data_c = DATA_WIDTH'(level[15:0]);
            2'd1:    rd_data_c = DATA_WIDTH'(level[SW_WIDTH-1:16]);
            2'd2:    rd_data_c = DATA_WIDTH'(pending);
            default: rd_data_c = DATA_WIDTH'(level[IN_W-1:SW_WIDTH]);
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            input_data <= '0;
        end else if (rd_en) begin
            input_data <= rd_data_c;
        end
    end

endmodule

// File: tb/tb_switch_button_io.sv
// Bench for switch_button_io: directed test-plan steps plus random stimulus,
// checked every cycle against a sample-list reference model.
module tb_switch_button_io;

    localparam int unsigned SW  = 24;
    localparam int unsigned BW  = 5;
    localparam int unsigned N   = SW + BW;
    localparam int unsigned DBC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sc, io;
    logic [1:0]    addr;
    logic [SW-1:0] sw;
    logic [BW-1:0] btn;
    logic [15:0]   input_data;
    logic          btn_event;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [N-1:0]  m_level;
    logic [BW-1:0] m_pend;
    logic [15:0]   m_data;
    logic [N-1:0]  dq[$];
    logic [N-1:0]  smp[$];
    int            m_edge;

    switch_button_io #(
        .SW_WIDTH(SW), .BTN_WIDTH(BW), .DB_CYCLES(DBC), .DATA_WIDTH(16)
    ) dut (
        .clock(clk), .reset(rst_n), .SwitchCtrl(sc), .ioRead(io), .addr(addr),
        .switches(sw), .buttons(btn), .input_data(input_data), .btn_event(btn_event)
    );

    always #5 clk = ~clk;

    // New debounced level: on a sample tick each bit takes the current sample
    // if the last three samples (two stored plus current) are all equal.
    function automatic logic [N-1:0] calc_level(logic [N-1:0] cur, logic [N-1:0] lvl,
                                                int e, logic [N-1:0] s_old, logic [N-1:0] s_new);
        logic [N-1:0] r;
        r = lvl;
        if ((e % DBC) == DBC - 1) begin
            for (int i = 0; i < N; i++) begin
                if (cur[i] == s_new[i] && cur[i] == s_old[i]) r[i] = cur[i];
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        dq      = '{};
        smp     = '{};
        dq.push_back('0);
        dq.push_back('0);
        smp.push_back('0);
        smp.push_back('0);
        m_level = '0;
        m_pend  = '0;
        m_data  = '0;
        m_edge  = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] raw, input logic rd, input logic [1:0] a);
        logic [N-1:0]  cur, nl;
        logic [BW-1:0] rs;
        cur = dq[0];
        nl  = calc_level(cur, m_level, m_edge, smp[0], smp[1]);
        if ((m_edge % DBC) == DBC - 1) begin
            void'(smp.pop_front());
            smp.push_back(cur);
        end
        rs = nl[N-1:SW] & ~m_level[N-1:SW];
        if (rd) begin
            case (a)
                2'd0: m_data = m_level[15:0];
                2'd1: m_data = {8'h00, m_level[SW-1:16]};
                2'd2: m_data = {11'd0, m_pend};
                default: m_data = {11'd0, m_level[N-1:SW]};
            endcase
        end
        if (rd && a == 2'd2) m_pend = rs;
        else                 m_pend = m_pend | rs;
        m_level = nl;
        void'(dq.pop_front());
        dq.push_back(raw);
        m_edge++;
    endtask

    // True if the coming edge will raise the debounced level of button 0.
    function automatic logic peek_rise0();
        logic [N-1:0] nl;
        nl = calc_level(dq[0], m_level, m_edge, smp[0], smp[1]);
        return nl[SW] & ~m_level[SW];
    endfunction

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge({btn, sw}, sc & io, addr);
        else       model_reset();
        @(negedge clk);
        chk16("data_model", input_data, m_data);
        chk1("event_model", btn_event, m_pend != '0);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [1:0] a);
        sc = 1'b1; io = 1'b1; addr = a;
        step();
        sc = 1'b0; io = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sc = 1'b0; io = 1'b0; addr = 2'd0;
        sw = '1; btn = '1;
        model_reset();

        // Reset with all pins high
        cyc(3);
        chk16("rst_data", input_data, 16'h0000);
        chk1("rst_event", btn_event, 1'b0);
        rst_n = 1'b1;
        cyc(20);
        chk16("no_read_data", input_data, 16'h0000);
        sw = '0; btn = '0;
        cyc(20);
        rd(2'd2);
        chk16("clear_initial", input_data, 16'h001F);

        // Switch read
        sw = 24'hA5C3F0;
        cyc(20);
        rd(2'd0);
        chk16("sw_lo", input_data, 16'hC3F0);
        rd(2'd1);
        chk16("sw_hi", input_data, 16'h00A5);

        // Glitch rejection
        sw = '0;
        cyc(20);
        sw[0] = 1'b1;
        cyc(5);
        sw[0] = 1'b0;
        cyc(20);
        rd(2'd0);
        chk16("glitch", input_data, 16'h0000);

        // Button press and read-to-clear
        btn[2] = 1'b1;
        cyc(20);
        chk1("press_event", btn_event, 1'b1);
        rd(2'd2);
        chk16("pend_read", input_data, 16'h0004);
        chk1("event_cleared", btn_event, 1'b0);
        rd(2'd2);
        chk16("pend_reread", input_data, 16'h0000);
        rd(2'd3);
        chk16("btn_level", input_data, 16'h0004);

        // Simultaneous clear and set
        btn[2] = 1'b0;
        cyc(20);
        btn[2] = 1'b1;
        cyc(20);
        btn[0] = 1'b1;
        begin
            int guard;
            guard = 0;
            while (!peek_rise0() && guard < 40) begin
                step();
                guard++;
            end
            tests++;
            assert (guard < 40) else begin
                fails++;
                $error("FAIL qualify_timeout observed=%0d expected<40", guard);
            end
        end
        rd(2'd2);
        chk16("clr_set_data", input_data, 16'h0004);
        chk1("clr_set_event", btn_event, 1'b1);
        rd(2'd2);
        chk16("clr_set_left", input_data, 16'h0001);

        // Hold without ioRead
        sc = 1'b1; io = 1'b0; addr = 2'd0;
        sw = 24'h123456;
        cyc(20);
        chk16("hold", input_data, 16'h0001);
        sc = 1'b0;

        // Mid-operation reset
        btn = '0;
        cyc(20);
        btn = 5'b00011;
        cyc(20);
        chk1("pend3_event", btn_event, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk1("async_event", btn_event, 1'b0);
        chk16("async_data", input_data, 16'h0000);
        cyc(3);
        rst_n = 1'b1;
        cyc(8);
        chk1("requal_wait", btn_event, 1'b0);
        cyc(10);
        rd(2'd2);
        chk16("requal_pend", input_data, 16'h0003);

        // Random stimulus against the model
        for (int k = 0; k < 300; k++) begin
            int hold;
            case ($urandom_range(0, 3))
                0: sw = SW'($urandom);
                1: btn = BW'($urandom);
                2: sw[$urandom_range(0, SW - 1)] ^= 1'b1;
                default: btn[$urandom_range(0, BW - 1)] ^= 1'b1;
            endcase
            hold = $urandom_range(1, 15);
            for (int j = 0; j < hold; j++) begin
                sc   = ($urandom_range(0, 3) == 0);
                io   = ($urandom_range(0, 2) != 0);
                addr = 2'($urandom_range(0, 3));
                step();
            end
            sc = 1'b0; io = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
